serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 83 ++++++++
 tb/tb_serial_subtractor.sv | 127 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial diff = a - b - bin, LSB first, borrow held in a flop,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] ar, bs, ds;
  logic [CW-1:0]    cnt;
  logic             br, sa, sb;
  logic             d, br_next, last;
  logic [WIDTH-1:0] ds_next;
  assign d        = ar[0] ^ bs[0] ^ br;
  assign br_next  = (~ar[0] & bs[0]) | (~(ar[0] ^ bs[0]) & br);
  assign ds_next  = {d, ds[WIDTH-1:1]};
  assign last     = cnt == CW'(WIDTH - 1);
  assign in_ready = state == IDLE;
  // ds accumulates privately so diff holds the previous result during SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ar        <= '0;
      bs        <= '0;
      ds        <= '0;
      cnt       <= '0;
      br        <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ar    <= a;
          bs    <= b;
          br    <= bin;
          sa    <= a[WIDTH-1];
          sb    <= b[WIDTH-1];
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          ar  <= ar >> 1;
          bs  <= bs >> 1;
          br  <= br_next;
          ds  <= ds_next;
          cnt <= last ? cnt : cnt + 1'b1;
          if (last) begin
            diff      <= ds_next;
            bout      <= br_next;
            zero      <= ds_next == '0;
            ovf       <= (sa != sb) && (d != sa);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against a
// queue-based scoreboard fed by an arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 4;
  typedef struct packed {logic [W-1:0] d; logic bo, z, o;} res_t;
  logic         clk = 0, rst_n = 0, in_valid = 0, in_ready, bin = 0;
  logic         out_valid, out_ready = 0, bout, zero, ovf;
  logic [W-1:0] a = '0, b = '0, diff;
  int           checks = 0, errors = 0;
  res_t         q[$];
  res_t         e;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] f;
    res_t r;
    f = {1'b0, x} - {1'b0, y} - (W + 1)'(c);
    r.d  = f[W-1:0];
    r.bo = f[W];
    r.z  = r.d == '0;
    r.o  = (x[W-1] != y[W-1]) && (r.d[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change only #1 after posedge, so a negedge sample predicts the next edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else begin
      if (out_valid && out_ready) begin
        chk("result_expected", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_diff", int'(diff), int'(e.d));
          chk("sb_bout", int'(bout), int'(e.bo));
          chk("sb_zero", int'(zero), int'(e.z));
          chk("sb_ovf", int'(ovf), int'(e.o));
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, bin));
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic [W-1:0] ed, input logic busy);
    int n;
    chk("idle_ready", int'(in_ready), 1);
    a = ta; b = tb; bin = tc; in_valid = 1;
    @(posedge clk); #1;
    in_valid = busy; a = ~ta; b = ~tb; bin = ~tc;
    chk("busy_ready", int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 3 * W) begin @(posedge clk); #1; n++; end
    chk("latency", n, W);
    chk("diff", int'(diff), int'(ed));
  endtask

  task automatic release_result();
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("released_valid", int'(out_valid), 0);
    chk("released_ready", int'(in_ready), 1);
  endtask

  initial begin
    int n;
    #2;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_diff", int'({diff, bout, zero, ovf}), 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    send(4'd9, 4'd3, 0, 4'h6, 0); chk("bout_9_3", int'(bout), 0); release_result();
    send(4'd3, 4'd9, 0, 4'hA, 0); chk("bout_3_9", int'(bout), 1); release_result();
    send(4'd5, 4'd5, 0, 4'h0, 0); chk("zero_5_5", int'(zero), 1); release_result();
    send(4'd0, 4'd0, 1, 4'hF, 0); chk("bout_bin", int'(bout), 1); release_result();
    send(4'd7, 4'd8, 0, 4'hF, 0); chk("ovf_7_8", int'(ovf), 1); release_result();
    send(4'd8, 4'd1, 0, 4'h7, 1); chk("ovf_8_1", int'(ovf), 1);
    for (int i = 0; i < 5; i++) begin
      a = 4'(i); b = 4'(i + 3); @(posedge clk); #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_ready", int'(in_ready), 0);
      chk("hold_out", int'({diff, bout, zero, ovf}), int'({4'h7, 1'b0, 1'b0, 1'b1}));
    end
    release_result();
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 200; i++) begin
      a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      @(posedge clk); #1;
      n = 1;
      while (!in_ready && n < 5 * W) begin @(posedge clk); #1; n++; end
      if (i < 20) chk("issue_interval", n, W + 2);
    end
    in_valid = 0; out_ready = 0;
    chk("drained", q.size(), 0);
    a = 4'd6; b = 4'd2; bin = 0; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 0; #1;
    chk("midrst_ready", int'(in_ready), 1);
    chk("midrst_out", int'({out_valid, diff, bout, zero, ovf}), 0);
    @(posedge clk); #1; rst_n = 1;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
      chk("no_valid_after_rst", int'(out_valid), 0);
    end
    send(4'd12, 4'd4, 0, 4'h8, 0); release_result();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
